// File: rtl/adsr_env.sv
// ADSR envelope generator and sample amplitude modulator, one envelope step per sample strobe.
// Latency: sample_out/out_valid/env_* update one clk after in_ready; no backpressure (strobe-driven).
// Optional build macro ADSR_EXP_RELEASE_EN selects exponential release; default is linear release.
module adsr_env #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int GAIN_WIDTH   = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           gate,
  input  logic                           in_ready,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  input  logic        [GAIN_WIDTH-1:0]   attack_rate,
  input  logic        [GAIN_WIDTH-1:0]   decay_rate,
  input  logic        [GAIN_WIDTH-1:0]   sustain_level,
  input  logic        [GAIN_WIDTH-1:0]   release_rate,
  output logic signed [SAMPLE_WIDTH-1:0] sample_out,
  output logic                           out_valid,
  output logic        [GAIN_WIDTH-1:0]   env_level,
  output logic        [2:0]              env_state,
  output logic                           busy
);

  localparam int SW = SAMPLE_WIDTH;
  localparam int GW = GAIN_WIDTH;
  localparam logic [GW-1:0] LMAX = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] level, level_nxt;

  // Candidate next levels for each envelope segment, computed every cycle.
  logic [GW:0]   atk_sum;
  logic [GW-1:0] atk_level;
  logic [GW:0]   dec_diff;
  logic [GW-1:0] dec_level;
  logic [GW-1:0] rel_level;

  // Modulator: sample times unsigned level, scaled back by the level full scale.
  logic signed [SW+GW:0]  prod;
  logic signed [SW-1:0]   mult_out;
  logic                   unused_prod;

  // Reset is asserted asynchronously but released on a clk edge, so no register
  // sees a reset removal close to its capture edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  // Two-flop reset release synchroniser.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  // Attack: saturating add in GW+1 bits; a zero rate jumps straight to full scale.
  always_comb begin
    atk_sum = {1'b0, level} + {1'b0, attack_rate};
    if ((attack_rate == '0) || (atk_sum >= {1'b0, LMAX})) begin
      atk_level = LMAX;
    end else begin
      atk_level = atk_sum[GW-1:0];
    end
  end

  // Decay: subtract without wrap and clamp at the sustain level; a zero rate
  // lands on sustain at once. A level already under sustain is pulled up to it.
  always_comb begin
    dec_diff = {1'b0, level} - {1'b0, decay_rate};
    if ((decay_rate == '0) || dec_diff[GW] || (dec_diff[GW-1:0] < sustain_level)) begin
      dec_level = sustain_level;
    end else begin
      dec_level = dec_diff[GW-1:0];
    end
  end

`ifdef ADSR_EXP_RELEASE_EN
  logic [3:0]    rel_shift;
  logic [GW-1:0] rel_step;
  logic          unused_rel;

  assign unused_rel = ^release_rate[GW-1:4];

  // Exponential release: step is level >> rate[3:0], at least 1 so it always
  // reaches zero; shift 0 empties the envelope in one strobe.
  always_comb begin
    rel_shift = release_rate[3:0];
    rel_step  = level >> rel_shift;
    if (rel_step == '0) begin
      rel_step = GW'(1);
    end
    if ((rel_shift == 4'd0) || (rel_step >= level)) begin
      rel_level = '0;
    end else begin
      rel_level = level - rel_step;
    end
  end
`else
  logic [GW:0] rel_diff;

  // Linear release: subtract without wrap, floor at zero; zero rate empties at once.
  always_comb begin
    rel_diff = {1'b0, level} - {1'b0, release_rate};
    if ((release_rate == '0) || rel_diff[GW]) begin
      rel_level = '0;
    end else begin
      rel_level = rel_diff[GW-1:0];
    end
  end
`endif

  // Next-state and next-level decision; nothing moves without a sample strobe.
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    if (in_ready) begin
      if (gate && ((state == S_IDLE) || (state == S_RELEASE))) begin
        // Retrigger continues from the current level, stepping on this strobe.
        level_nxt = atk_level;
        state_nxt = (atk_level == LMAX) ? S_DECAY : S_ATTACK;
      end else if (!gate && ((state == S_ATTACK) || (state == S_DECAY) ||
                             (state == S_SUSTAIN))) begin
        // Note-off only changes the segment; the level holds for this strobe.
        state_nxt = S_RELEASE;
      end else begin
        case (state)
          S_IDLE: begin
            level_nxt = '0;
          end
          S_ATTACK: begin
            level_nxt = atk_level;
            if (atk_level == LMAX) begin
              state_nxt = S_DECAY;
            end
          end
          S_DECAY: begin
            level_nxt = dec_level;
            if (dec_level == sustain_level) begin
              state_nxt = S_SUSTAIN;
            end
          end
          S_SUSTAIN: begin
            level_nxt = sustain_level;
          end
          S_RELEASE: begin
            level_nxt = rel_level;
            if (rel_level == '0) begin
              state_nxt = S_IDLE;
            end
          end
          default: begin
            state_nxt = S_IDLE;
            level_nxt = '0;
          end
        endcase
      end
    end
  end

  // Envelope state and level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      level <= '0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
    end
  end

  // Signed multiply by the pre-update level; the zero-extended level keeps the
  // product sign from the sample, so the result magnitude never exceeds the input.
  always_comb begin
    prod        = sample_in * $signed({1'b0, level});
    mult_out    = prod[SW+GW-1:GW];
    unused_prod = ^{prod[SW+GW], prod[GW-1:0]};
  end

  // Output sample register and its one-cycle valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_out <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= in_ready;
      if (in_ready) begin
        sample_out <= mult_out;
      end
    end
  end

  assign env_level = level;
  assign env_state = state;
  assign busy      = (state != S_IDLE);

endmodule

// File: doc/adsr_env.md
Name: adsr_env

Overview:
- Parametrised, gate-driven ADSR envelope generator and amplitude modulator for the synth voice path.
- Sits between the oscillator/mixer and the codec, advancing one envelope step per codec sample strobe (48 kHz).
- Successor to the fixed-timing, shift-add ADSR. Adds:
  - note gate with retrigger;
  - run-time attack/decay/release rates and sustain level;
  - true multiply gain;
  - parametrised sample/gain widths.

Parameters:
- SAMPLE_WIDTH, 16: signed audio sample width.
- GAIN_WIDTH, 16: unsigned envelope level width. Level is Q0.GAIN_WIDTH; full scale LMAX = 2^GAIN_WIDTH-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- gate  in  1  note held; sampled only on in_ready
- in_ready  in  1  one-cycle sample strobe from codec
- sample_in  in  SAMPLE_WIDTH  signed input sample, valid with in_ready
- attack_rate  in  GAIN_WIDTH  level increment per sample in ATTACK; 0 = instantaneous
- decay_rate  in  GAIN_WIDTH  level decrement per sample in DECAY; 0 = instantaneous
- sustain_level  in  GAIN_WIDTH  SUSTAIN hold level
- release_rate  in  GAIN_WIDTH  level decrement per sample in RELEASE; 0 = instantaneous
- sample_out  out  SAMPLE_WIDTH  signed modulated sample, registered
- out_valid  out  1  one-cycle pulse, sample_out updated
- env_level  out  GAIN_WIDTH  current envelope level
- env_state  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
- busy  out  1  env_state != IDLE

Behaviour:
- Reset (async assert, sync deassert internally):
  - env_state=IDLE, env_level=0, sample_out=0, out_valid=0, busy=0.
- All state, level and output registers change only in the clk cycle after in_ready=1. No change on cycles without in_ready.
- Multiply:
  - sample_out <= (sample_in * {1'b0, env_level}) >>> GAIN_WIDTH, signed, truncated to SAMPLE_WIDTH.
  - Uses env_level before this strobe's update.
  - |sample_out| <= |sample_in|; -2^(SW-1) stays representable.
- Latency: out_valid pulses exactly 1 cycle after in_ready. Back-to-back strobes give back-to-back pulses.
- Transitions, evaluated per strobe in priority order:
  1. gate=1 in IDLE or RELEASE -> ATTACK. Level continues from current value (no reset to 0).
  2. gate=0 in ATTACK, DECAY or SUSTAIN -> RELEASE. Level unchanged this strobe.
  3. ATTACK:
     - level' = min(level + attack_rate, LMAX), computed in GAIN_WIDTH+1 bits, saturating.
     - If level' == LMAX -> DECAY.
     - attack_rate=0 -> level'=LMAX.
  4. DECAY:
     - level' = max(level - decay_rate, sustain_level), no wrap.
     - If level' == sustain_level -> SUSTAIN.
     - decay_rate=0 -> level'=sustain_level.
  5. SUSTAIN: level' = sustain_level, tracking live changes.
  6. RELEASE:
     - level' = max(level - release_rate, 0).
     - If level' == 0 -> IDLE.
     - release_rate=0 -> level'=0.
  7. IDLE with gate=0: level stays 0.
- Boundary rules:
  - sustain_level=LMAX: DECAY completes in one strobe.
  - sustain_level=0 with gate held: level sits at 0 in SUSTAIN, not IDLE.
  - Gate toggled between strobes is invisible; only the level at the strobe matters.
  - Reset mid-note returns to IDLE/0 immediately, regardless of clk.
  - Rate inputs are sampled each strobe; changes take effect on the next strobe.

Optional Feature:
- Macro: ADSR_EXP_RELEASE_EN.
- Defined: RELEASE uses an exponential decay.
  - Decrement is max(level >> release_rate[3:0], 1).
  - Upper release_rate bits are ignored.
  - release_rate[3:0]=0 -> level'=0.
  - Same IDLE-on-0 rule applies.
- Undefined: linear release as above.
- All other states are identical in both builds.

Test Plan:
- Reset held, strobes applied -> env_state=0, sample_out=0, out_valid=0. Release reset: first strobe with gate=0 keeps IDLE, out_valid pulses with sample_out=0.
- gate=1, attack_rate=0x2000, sample_in=0x4000 constant:
  - env_level steps 0x2000, 0x4000 ... 0xE000.
  - 8th strobe saturates at 0xFFFF -> DECAY.
  - sample_out on the strobe after level=0x8000 is 0x2000.
- Continue with decay_rate=0x1000, sustain_level=0x8000:
  - Level drops 0xFFFF -> 0xEFFF ... -> clamps at 0x8000 -> SUSTAIN; holds.
  - sample_in=-32768 -> sample_out=-16384.
- In SUSTAIN drop gate, release_rate=0x3000:
  - RELEASE; level 0x8000 -> 0x5000 -> 0x2000 -> 0 -> IDLE, busy=0.
  - Re-raise gate at level 0x2000 -> ATTACK from 0x2000.
- gate=0 during ATTACK at level 0x6000 -> RELEASE next strobe, level stays 0x6000. Assert reset mid-RELEASE without clk edge -> outputs 0 immediately.
- ADSR_EXP_RELEASE_EN defined, level 0x8000, release_rate=1:
  - Level 0x4000, 0x2000 ... 1, 0 -> IDLE after 16 release strobes.
  - release_rate=0 -> IDLE after one strobe.
